jtag_debug_sysclk_cmdq: RTL and testbench
=========================================

Name: jtag_debug_sysclk_cmdq

Overview:
System-clock-side receiver for the Nios II JTAG debug path, generalised from the fixed 38-bit/2-bit-IR sysclk decoder. It synchronises the TCK-domain update strobes (vs_uir, vs_udr), latches the instruction register, and queues each {IR, shift-register} command into a DEPTH-entry FIFO. On pop it emits one-hot take_action / take_no_action strobes per instruction channel, with ready/valid backpressure and overflow accounting.

Parameters:
SR_W, 38, shift-register / jdo width
IR_W, 2, instruction register width; channel count N_CH = 2**IR_W
DEPTH, 4, command FIFO depth, power of 2, at least 2
ACTION_BIT, 37, jdo bit selecting take_action (1) vs take_no_action (0)
SYNC_STAGES, 2, synchroniser flops for vs_uir / vs_udr, at least 2

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sr  in  SR_W  TCK-domain shift register; stable while vs_udr high
ir_in  in  IR_W  TCK-domain IR; stable while vs_uir high
vs_uir  in  1  virtual-state update-IR level, asynchronous to clk
vs_udr  in  1  virtual-state update-DR level, asynchronous to clk
cmd_ready  in  1  consumer accepts head command
cmd_valid  out  1  FIFO non-empty
jdo  out  SR_W  head command data
cmd_ir  out  IR_W  head command instruction
take_action  out  N_CH  one-hot pulse on pop when jdo[ACTION_BIT]=1
take_no_action  out  N_CH  one-hot pulse on pop when jdo[ACTION_BIT]=0
st_overflow  out  1  sticky: command dropped because FIFO full
drop_count  out  8  saturating count of dropped commands
fifo_level  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset: all outputs 0, FIFO empty, synchronisers 0, ir_latched 0, drop_count 0.
- Synchroniser: SYNC_STAGES flops per strobe, then one extra flop for rising-edge detection. An edge is registered SYNC_STAGES+1 clk cycles after the input rises. Falling edges are ignored.
- uir_edge: ir_latched <= ir_in in the same cycle.
- udr_edge: push {ir_latched, sr} when not full. If uir_edge and udr_edge occur in the same cycle, the push uses the new ir_in value.
- Write-while-full: the entry is dropped, st_overflow set, drop_count increments and saturates at 255. FIFO contents are unchanged.
- Pop = cmd_valid & cmd_ready. jdo/cmd_ir show the head entry combinationally from FIFO RAM or registers; they hold while cmd_valid & !cmd_ready.
- take_action[i] = pop & (cmd_ir==i) & jdo[ACTION_BIT], registered, so the pulse is 1 cycle wide, 1 cycle after the pop.
- take_no_action[i] is the same with !jdo[ACTION_BIT]. At most one bit of the two vectors is high per cycle.
- Simultaneous push and pop when full: the pop frees a slot, the push is accepted, level is unchanged, no overflow. When empty, a push is not poppable the same cycle (no fall-through), so cmd_valid rises the cycle after the push.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level is tracked separately, range 0..DEPTH.
- st_overflow and drop_count clear only on reset.
- Reset mid-operation: the FIFO is flushed immediately (async), any pending strobe pulse is lost, and no action strobe is emitted after reset deasserts.

Test Plan:
- Reset then idle: all outputs 0, fifo_level=0, cmd_valid=0 for 20 cycles.
- vs_uir pulse with ir_in=2'b10, then vs_udr pulse with sr=38'h20_0000_1234 and cmd_ready=1 -> cmd_valid rises exactly 4 cycles after vs_udr rises; jdo=38'h20_0000_1234; take_action=4'b0100 for one cycle; take_no_action=0.
- ir=2'b01, sr[37]=0, cmd_ready=1 -> take_no_action=4'b0010 single-cycle pulse; take_action stays 0.
- cmd_ready=0, 6 vs_udr pulses (DEPTH=4) -> fifo_level=4, st_overflow=1, drop_count=2. Then cmd_ready=1 -> 4 pops in order with original sr values, level returns to 0.
- FIFO full, cmd_ready=1 on the same cycle as udr_edge -> level stays 4, drop_count unchanged.
- Assert reset with 3 entries queued and cmd_ready=0 -> cmd_valid=0, fifo_level=0, drop_count=0 immediately; no take_* pulse after release.

Source files
------------

// File: rtl/jtag_debug_sysclk_cmdq.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// jtag_debug_sysclk_cmdq
//
// System-clock-side receiver for the JTAG debug path. The TCK-domain
// update-IR / update-DR levels are synchronised into clk and edge-detected.
// Update-IR latches the instruction register. Update-DR queues an
// {IR, shift-register} command into a DEPTH-entry FIFO. When the consumer
// pops a command, the block emits a registered one-hot take_action or
// take_no_action strobe for that instruction channel. Commands that arrive
// while the FIFO is full are dropped and counted.
//
// Ports:
//   clk, reset        system clock, asynchronous active-high reset
//   sr                TCK-domain shift register, stable while vs_udr is high
//   ir_in             TCK-domain instruction register, stable while vs_uir is high
//   vs_uir, vs_udr    update-IR / update-DR levels, asynchronous to clk
//   cmd_ready         consumer accepts the head command
//   cmd_valid         FIFO holds at least one command
//   jdo, cmd_ir       head command (zero while the FIFO is empty)
//   take_action       one-hot pulse, one cycle after a pop with jdo[ACTION_BIT]=1
//   take_no_action    one-hot pulse, one cycle after a pop with jdo[ACTION_BIT]=0
//   st_overflow       sticky flag: a command was dropped because the FIFO was full
//   drop_count        saturating count of dropped commands
//   fifo_level        current FIFO occupancy, 0..DEPTH
// ----------------------------------------------------------------------------
module jtag_debug_sysclk_cmdq #(
   parameter int SR_W        = 38,
   parameter int IR_W        = 2,
   parameter int DEPTH       = 4,
   parameter int ACTION_BIT  = 37,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [SR_W-1:0]          sr,
   input  logic [IR_W-1:0]          ir_in,
   input  logic                     vs_uir,
   input  logic                     vs_udr,
   input  logic                     cmd_ready,
   output logic                     cmd_valid,
   output logic [SR_W-1:0]          jdo,
   output logic [IR_W-1:0]          cmd_ir,
   output logic [(2**IR_W)-1:0]     take_action,
   output logic [(2**IR_W)-1:0]     take_no_action,
   output logic                     st_overflow,
   output logic [7:0]               drop_count,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int N_CH  = 2**IR_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int ENT_W = IR_W + SR_W;

   // Synchronisers and edge detectors
   logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
   logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
   logic                   uir_prev_q, uir_prev_d;
   logic                   udr_prev_q, udr_prev_d;
   logic                   uir_edge_q, uir_edge_d;
   logic                   udr_edge_q, udr_edge_d;

   // Instruction latch
   logic [IR_W-1:0]        ir_latched_q, ir_latched_d;

   // Command FIFO
   logic [ENT_W-1:0]       mem_q [DEPTH];
   logic [ENT_W-1:0]       mem_d [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]       level_q, level_d;

   // Status and action strobes
   logic                   st_overflow_q, st_overflow_d;
   logic [7:0]             drop_count_q, drop_count_d;
   logic [N_CH-1:0]        take_action_q, take_action_d;
   logic [N_CH-1:0]        take_no_action_q, take_no_action_d;

   logic                   full;
   logic                   pop;
   logic                   push_ok;
   logic                   drop;
   logic [IR_W-1:0]        push_ir;
   logic [ENT_W-1:0]       head;

   // -------------------------------------------------------------------------
   // Synchroniser chains. The edge is itself registered, so a rising input
   // produces a one-cycle udr_edge_q / uir_edge_q SYNC_STAGES+1 cycles later.
   // -------------------------------------------------------------------------
   always_comb begin
      uir_sync_d = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
      udr_sync_d = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
      uir_prev_d = uir_sync_q[SYNC_STAGES-1];
      udr_prev_d = udr_sync_q[SYNC_STAGES-1];
      uir_edge_d = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;
      udr_edge_d = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
   end

   // -------------------------------------------------------------------------
   // FIFO control
   // -------------------------------------------------------------------------
   assign full      = (level_q == LVL_W'(DEPTH));
   assign cmd_valid = (level_q != '0);
   assign pop       = cmd_valid & cmd_ready;
   // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
   assign push_ok   = udr_edge_q & (~full | pop);
   assign drop      = udr_edge_q & full & ~pop;
   // When both update strobes coincide the freshly updated IR wins.
   assign push_ir   = uir_edge_q ? ir_in : ir_latched_q;

   assign head      = mem_q[rd_ptr_q];
   assign jdo       = cmd_valid ? head[SR_W-1:0]     : '0;
   assign cmd_ir    = cmd_valid ? head[ENT_W-1:SR_W] : '0;

   always_comb begin
      ir_latched_d = ir_latched_q;
      if (uir_edge_q) begin
         ir_latched_d = ir_in;
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push_ok) begin
         mem_d[wr_ptr_q] = {push_ir, sr};
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      st_overflow_d = st_overflow_q;
      drop_count_d  = drop_count_q;
      if (drop) begin
         st_overflow_d = 1'b1;
         if (drop_count_q != 8'hFF) begin
            drop_count_d = drop_count_q + 8'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Action strobes, registered one cycle after the pop
   // -------------------------------------------------------------------------
   always_comb begin
      take_action_d    = '0;
      take_no_action_d = '0;
      if (pop) begin
         if (jdo[ACTION_BIT]) begin
            take_action_d[cmd_ir] = 1'b1;
         end else begin
            take_no_action_d[cmd_ir] = 1'b1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         uir_sync_q       <= '0;
         udr_sync_q       <= '0;
         uir_prev_q       <= 1'b0;
         udr_prev_q       <= 1'b0;
         uir_edge_q       <= 1'b0;
         udr_edge_q       <= 1'b0;
         ir_latched_q     <= '0;
         wr_ptr_q         <= '0;
         rd_ptr_q         <= '0;
         level_q          <= '0;
         st_overflow_q    <= 1'b0;
         drop_count_q     <= '0;
         take_action_q    <= '0;
         take_no_action_q <= '0;
      end else begin
         uir_sync_q       <= uir_sync_d;
         udr_sync_q       <= udr_sync_d;
         uir_prev_q       <= uir_prev_d;
         udr_prev_q       <= udr_prev_d;
         uir_edge_q       <= uir_edge_d;
         udr_edge_q       <= udr_edge_d;
         ir_latched_q     <= ir_latched_d;
         wr_ptr_q         <= wr_ptr_d;
         rd_ptr_q         <= rd_ptr_d;
         level_q          <= level_d;
         st_overflow_q    <= st_overflow_d;
         drop_count_q     <= drop_count_d;
         take_action_q    <= take_action_d;
         take_no_action_q <= take_no_action_d;
      end
   end

   // FIFO storage needs no reset: the outputs are masked while empty.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   assign take_action    = take_action_q;
   assign take_no_action = take_no_action_q;
   assign st_overflow    = st_overflow_q;
   assign drop_count     = drop_count_q;
   assign fifo_level     = level_q;

endmodule

// File: tb/tb_jtag_debug_sysclk_cmdq.sv
`timescale 1ns/1ps
// Testbench for jtag_debug_sysclk_cmdq: directed stimulus with a scoreboard
// queue of expected commands and a negedge monitor that checks every pop and
// every cycle of the take_action / take_no_action strobes.
module tb_jtag_debug_sysclk_cmdq;

   localparam int SR_W  = 38;
   localparam int IR_W  = 2;
   localparam int DEPTH = 4;
   localparam int N_CH  = 4;
   localparam int LVL_W = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic [SR_W-1:0]   sr;
   logic [IR_W-1:0]   ir_in;
   logic              vs_uir;
   logic              vs_udr;
   logic              cmd_ready;
   logic              cmd_valid;
   logic [SR_W-1:0]   jdo;
   logic [IR_W-1:0]   cmd_ir;
   logic [N_CH-1:0]   take_action;
   logic [N_CH-1:0]   take_no_action;
   logic              st_overflow;
   logic [7:0]        drop_count;
   logic [LVL_W-1:0]  fifo_level;

   always #5 clk = ~clk;

   jtag_debug_sysclk_cmdq #(
      .SR_W(SR_W), .IR_W(IR_W), .DEPTH(DEPTH), .ACTION_BIT(37), .SYNC_STAGES(2)
   ) dut (
      .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in),
      .vs_uir(vs_uir), .vs_udr(vs_udr), .cmd_ready(cmd_ready),
      .cmd_valid(cmd_valid), .jdo(jdo), .cmd_ir(cmd_ir),
      .take_action(take_action), .take_no_action(take_no_action),
      .st_overflow(st_overflow), .drop_count(drop_count), .fifo_level(fifo_level)
   );

   int n_checks = 0;
   int n_errs   = 0;

   logic [IR_W+SR_W-1:0] exp_q[$];
   logic [IR_W+SR_W-1:0] exp_e;
   logic [N_CH-1:0]      exp_ta  = '0;
   logic [N_CH-1:0]      exp_tna = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errs++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // Monitor: compares the head on every pop and the strobes on every cycle.
   always @(negedge clk) begin
      if (reset) begin
         exp_ta  = '0;
         exp_tna = '0;
      end else begin
         check("take_action", 64'(take_action), 64'(exp_ta));
         check("take_no_action", 64'(take_no_action), 64'(exp_tna));
         exp_ta  = '0;
         exp_tna = '0;
         if (cmd_valid && cmd_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errs++;
               $display("FAIL unexpected_pop: got jdo=%0h cmd_ir=%0h required no pop", jdo, cmd_ir);
            end else begin
               exp_e = exp_q.pop_front();
               check("jdo", 64'(jdo), 64'(exp_e[SR_W-1:0]));
               check("cmd_ir", 64'(cmd_ir), 64'(exp_e[IR_W+SR_W-1:SR_W]));
               if (exp_e[37]) exp_ta[exp_e[IR_W+SR_W-1:SR_W]] = 1'b1;
               else           exp_tna[exp_e[IR_W+SR_W-1:SR_W]] = 1'b1;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic uir_pulse(input logic [IR_W-1:0] v);
      ir_in  = v;
      vs_uir = 1'b1;
      tick(3);
      vs_uir = 1'b0;
      tick(4);
   endtask

   task automatic udr_pulse(input logic [SR_W-1:0] v);
      sr     = v;
      vs_udr = 1'b1;
      tick(3);
      vs_udr = 1'b0;
      tick(4);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      logic [SR_W-1:0] v;

      reset = 1'b1; sr = '0; ir_in = '0; vs_uir = 1'b0; vs_udr = 1'b0; cmd_ready = 1'b0;
      tick(3);
      check("reset_outputs",
            64'({cmd_valid, fifo_level, st_overflow, drop_count, jdo, cmd_ir, take_action, take_no_action}), 64'(0));
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 20; i++) begin
         tick(1);
         check("idle_outputs", 64'({cmd_valid, fifo_level, st_overflow, drop_count, jdo, cmd_ir}), 64'(0));
      end

      // IR=2, action bit set: cmd_valid 4 cycles after vs_udr rises
      uir_pulse(2'b10);
      cmd_ready = 1'b1;
      sr = 38'h20_0000_1234;
      exp_q.push_back({2'b10, 38'h20_0000_1234});
      vs_udr = 1'b1;
      lat = 0;
      do begin
         tick(1);
         lat++;
      end while (!cmd_valid && lat < 12);
      check("udr_latency", 64'(lat), 64'(4));
      vs_udr = 1'b0;
      tick(5);

      // IR=1, action bit clear
      uir_pulse(2'b01);
      exp_q.push_back({2'b01, 38'h00_0000_0055});
      udr_pulse(38'h00_0000_0055);
      tick(2);

      // Overflow: six commands into a four-deep FIFO with no consumer
      cmd_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         v = 38'(100 + i);
         if (i < 4) exp_q.push_back({2'b01, v});
         udr_pulse(v);
      end
      check("full_level", 64'(fifo_level), 64'(4));
      check("overflow_flag", 64'(st_overflow), 64'(1));
      check("drop_count_2", 64'(drop_count), 64'(2));
      cmd_ready = 1'b1;
      tick(8);
      check("drained_level", 64'(fifo_level), 64'(0));
      check("drained_queue", 64'(exp_q.size()), 64'(0));

      // Push and pop in the same cycle while full
      cmd_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         v = 38'h20_0000_0200 + 38'(i);
         exp_q.push_back({2'b01, v});
         udr_pulse(v);
      end
      check("refill_level", 64'(fifo_level), 64'(4));
      sr = 38'h00_0000_03ff;
      exp_q.push_back({2'b01, 38'h00_0000_03ff});
      vs_udr = 1'b1;
      tick(3);
      cmd_ready = 1'b1;
      tick(1);
      cmd_ready = 1'b0;
      vs_udr = 1'b0;
      check("pushpop_level", 64'(fifo_level), 64'(4));
      check("pushpop_drops", 64'(drop_count), 64'(2));
      tick(3);
      check("pushpop_level_hold", 64'(fifo_level), 64'(4));
      cmd_ready = 1'b1;
      tick(8);
      check("pushpop_drained", 64'(fifo_level), 64'(0));
      check("pushpop_queue", 64'(exp_q.size()), 64'(0));

      // Reset with three entries queued and a strobe in flight
      cmd_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v = 38'h00_0000_0700 + 38'(i);
         exp_q.push_back({2'b01, v});
         udr_pulse(v);
      end
      check("pre_reset_level", 64'(fifo_level), 64'(3));
      sr = 38'h00_0000_0077;
      vs_udr = 1'b1;
      tick(2);
      #2;
      reset = 1'b1;
      #1;
      check("reset_cmd_valid", 64'(cmd_valid), 64'(0));
      check("reset_level", 64'(fifo_level), 64'(0));
      check("reset_drop_count", 64'(drop_count), 64'(0));
      check("reset_overflow", 64'(st_overflow), 64'(0));
      exp_q.delete();
      vs_udr = 1'b0;
      tick(2);
      reset = 1'b0;
      cmd_ready = 1'b1;
      tick(12);
      check("post_reset_valid", 64'(cmd_valid), 64'(0));
      check("post_reset_level", 64'(fifo_level), 64'(0));

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule
